// File: rtl/md5_round_ctrl.sv
// Step sequencer for the 64-step MD5 compression datapath. It issues the load, step
// and accumulate strobes, decodes the per-step word index and rotate amount, and counts blocks.
module md5_round_ctrl #(
   parameter int BLK_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             new_msg,
   input  logic             stall,
   output logic             ready,
   output logic             busy,
   output logic             init_iv,
   output logic             ld_abcd,
   output logic             step_en,
   output logic [5:0]       cnt,
   output logic [3:0]       g,
   output logic [4:0]       s,
   output logic [1:0]       func,
   output logic             acc_hash,
   output logic             done,
   output logic [BLK_W-1:0] blk_cnt
);

   typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, DONE} state_t;

   state_t           state_reg;
   logic [5:0]       cnt_reg;
   logic [BLK_W-1:0] blk_cnt_reg;
   logic             new_msg_reg;
   logic             ready_reg;
   logic             busy_reg;
   logic             init_iv_reg;
   logic             ld_abcd_reg;
   logic             acc_hash_reg;
   logic             done_reg;

   // Each strobe register is loaded with its value for the state being entered,
   // so the strobe is high during exactly that state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         blk_cnt_reg  <= '0;
         new_msg_reg  <= 1'b0;
         ready_reg    <= 1'b1;
         busy_reg     <= 1'b0;
         init_iv_reg  <= 1'b0;
         ld_abcd_reg  <= 1'b0;
         acc_hash_reg <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  state_reg   <= INIT;
                  new_msg_reg <= new_msg;
                  ready_reg   <= 1'b0;
                  busy_reg    <= 1'b1;
                  ld_abcd_reg <= 1'b1;
                  init_iv_reg <= new_msg;
               end
            end
            INIT: begin
               state_reg   <= ROUND;
               cnt_reg     <= '0;
               ld_abcd_reg <= 1'b0;
               init_iv_reg <= 1'b0;
               if (new_msg_reg) begin
                  blk_cnt_reg <= '0;
               end
            end
            ROUND: begin
               if (!stall) begin
                  if (cnt_reg == 6'd63) begin
                     cnt_reg      <= '0;
                     state_reg    <= FINAL;
                     acc_hash_reg <= 1'b1;
                  end else begin
                     cnt_reg <= cnt_reg + 6'd1;
                  end
               end
            end
            FINAL: begin
               state_reg    <= DONE;
               acc_hash_reg <= 1'b0;
               busy_reg     <= 1'b0;
               done_reg     <= 1'b1;
               blk_cnt_reg  <= blk_cnt_reg + BLK_W'(1);
            end
            DONE: begin
               state_reg <= IDLE;
               done_reg  <= 1'b0;
               ready_reg <= 1'b1;
            end
            default: begin
               state_reg    <= IDLE;
               cnt_reg      <= '0;
               ready_reg    <= 1'b1;
               busy_reg     <= 1'b0;
               init_iv_reg  <= 1'b0;
               ld_abcd_reg  <= 1'b0;
               acc_hash_reg <= 1'b0;
               done_reg     <= 1'b0;
            end
         endcase
      end
   end

   // step_en is the one output that follows stall directly, so a stalled cycle never executes.
   assign step_en  = (state_reg == ROUND) && !stall;
   assign ready    = ready_reg;
   assign busy     = busy_reg;
   assign init_iv  = init_iv_reg;
   assign ld_abcd  = ld_abcd_reg;
   assign acc_hash = acc_hash_reg;
   assign done     = done_reg;
   assign cnt      = cnt_reg;
   assign blk_cnt  = blk_cnt_reg;
   assign func     = cnt_reg[5:4];

   // Multiples of 16 vanish mod 16, so the low nibble of cnt is enough to find g.
   logic [3:0] lo;
   assign lo = cnt_reg[3:0];

   always_comb begin
      g = lo;
      case (cnt_reg[5:4])
         2'd0: g = lo;
         2'd1: g = 4'(lo * 4'd5 + 4'd1);
         2'd2: g = 4'(lo * 4'd3 + 4'd5);
         2'd3: g = 4'(lo * 4'd7);
         default: g = lo;
      endcase
   end

   always_comb begin
      s = 5'd0;
      case ({cnt_reg[5:4], cnt_reg[1:0]})
         4'h0: s = 5'd7;
         4'h1: s = 5'd12;
         4'h2: s = 5'd17;
         4'h3: s = 5'd22;
         4'h4: s = 5'd5;
         4'h5: s = 5'd9;
         4'h6: s = 5'd14;
         4'h7: s = 5'd20;
         4'h8: s = 5'd4;
         4'h9: s = 5'd11;
         4'hA: s = 5'd16;
         4'hB: s = 5'd23;
         4'hC: s = 5'd6;
         4'hD: s = 5'd10;
         4'hE: s = 5'd15;
         4'hF: s = 5'd21;
         default: s = 5'd0;
      endcase
   end

endmodule

// File: tb/tb_md5_round_ctrl.sv
// Directed bench for md5_round_ctrl; a second instance with a 2-bit block counter
// shares the stimulus so that counter wrap is visible.
module tb_md5_round_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       new_msg = 1'b0;
   logic       stall = 1'b0;

   logic       ready, busy, init_iv, ld_abcd, step_en, acc_hash, done;
   logic [5:0] cnt;
   logic [3:0] g;
   logic [4:0] s;
   logic [1:0] func;
   logic [15:0] blk_cnt;

   logic       ready2, busy2, init_iv2, ld_abcd2, step_en2, acc_hash2, done2;
   logic [5:0] cnt2;
   logic [3:0] g2;
   logic [4:0] s2;
   logic [1:0] func2;
   logic [1:0] blk_cnt2;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   md5_round_ctrl #(.BLK_W(16)) dut (
      .clk(clk), .rst(rst), .start(start), .new_msg(new_msg), .stall(stall),
      .ready(ready), .busy(busy), .init_iv(init_iv), .ld_abcd(ld_abcd),
      .step_en(step_en), .cnt(cnt), .g(g), .s(s), .func(func),
      .acc_hash(acc_hash), .done(done), .blk_cnt(blk_cnt)
   );

   md5_round_ctrl #(.BLK_W(2)) dut2 (
      .clk(clk), .rst(rst), .start(start), .new_msg(new_msg), .stall(stall),
      .ready(ready2), .busy(busy2), .init_iv(init_iv2), .ld_abcd(ld_abcd2),
      .step_en(step_en2), .cnt(cnt2), .g(g2), .s(s2), .func(func2),
      .acc_hash(acc_hash2), .done(done2), .blk_cnt(blk_cnt2)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Hand-computed decode vectors: step -> {g, s, func}
   task automatic spot(input int i);
      int eg, es, ef;
      bit hit;
      hit = 1'b1; eg = 0; es = 0; ef = 0;
      case (i)
         0:  begin eg = 0;  es = 7;  ef = 0; end
         1:  begin eg = 1;  es = 12; ef = 0; end
         15: begin eg = 15; es = 22; ef = 0; end
         16: begin eg = 1;  es = 5;  ef = 1; end
         17: begin eg = 6;  es = 9;  ef = 1; end
         20: begin eg = 5;  es = 5;  ef = 1; end
         31: begin eg = 12; es = 20; ef = 1; end
         32: begin eg = 5;  es = 4;  ef = 2; end
         35: begin eg = 14; es = 23; ef = 2; end
         47: begin eg = 2;  es = 23; ef = 2; end
         48: begin eg = 0;  es = 6;  ef = 3; end
         50: begin eg = 14; es = 15; ef = 3; end
         63: begin eg = 9;  es = 21; ef = 3; end
         default: hit = 1'b0;
      endcase
      if (hit) begin
         chk($sformatf("g@%0d", i), 32'(g), 32'(eg));
         chk($sformatf("s@%0d", i), 32'(s), 32'(es));
         chk($sformatf("func@%0d", i), 32'(func), 32'(ef));
      end
   endtask

   task automatic run_block(input logic nm, input int exp_blk, input int exp_blk2,
                            input int st_a, input int len_a, input int st_b, input int len_b,
                            input bit poke);
      int t0;
      int len;
      start = 1'b1; new_msg = nm;
      tick();
      start = 1'b0; new_msg = 1'b0;
      t0 = cyc - 1;
      chk("init_ld_abcd", 32'(ld_abcd), 32'd1);
      chk("init_iv", 32'(init_iv), 32'(nm));
      chk("init_busy", 32'(busy), 32'd1);
      chk("init_ready", 32'(ready), 32'd0);
      chk("init_step_en", 32'(step_en), 32'd0);
      for (int i = 0; i < 64; i++) begin
         if (poke && i == 10) start = 1'b1;
         if (poke && i == 60) start = 1'b0;
         tick();
         chk($sformatf("cnt@%0d", i), 32'(cnt), 32'(i));
         len = (i == st_a) ? len_a : ((i == st_b) ? len_b : 0);
         for (int k = 0; k < len; k++) begin
            stall = 1'b1;
            #1;
            chk($sformatf("stall_step_en@%0d", i), 32'(step_en), 32'd0);
            tick();
            chk($sformatf("stall_hold_cnt@%0d", i), 32'(cnt), 32'(i));
         end
         stall = 1'b0;
         #1;
         chk($sformatf("step_en@%0d", i), 32'(step_en), 32'd1);
         spot(i);
      end
      tick();
      chk("final_acc_hash", 32'(acc_hash), 32'd1);
      chk("final_cnt", 32'(cnt), 32'd0);
      chk("final_step_en", 32'(step_en), 32'd0);
      chk("final_done", 32'(done), 32'd0);
      tick();
      chk("done_pulse", 32'(done), 32'd1);
      chk("done_ready", 32'(ready), 32'd0);
      chk("done_busy", 32'(busy), 32'd0);
      chk("done_acc_hash", 32'(acc_hash), 32'd0);
      chk("done_latency", 32'(cyc - t0), 32'(67 + len_a + len_b));
      chk("blk_cnt", 32'(blk_cnt), 32'(exp_blk));
      chk("blk_cnt_w2", 32'(blk_cnt2), 32'(exp_blk2));
      tick();
      chk("idle_ready", 32'(ready), 32'd1);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      $display("block new_msg=%0d blk_cnt=%0d blk_cnt_w2=%0d stalls=%0d", nm, blk_cnt, blk_cnt2,
               len_a + len_b);
   endtask

   initial begin
      bit seen;
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cnt", 32'(cnt), 32'd0);
      chk("rst_blk_cnt", 32'(blk_cnt), 32'd0);
      chk("rst_strobes", 32'({init_iv, ld_abcd, step_en, acc_hash, done}), 32'd0);
      $display("reset idle ready=%0d cnt=%0d", ready, cnt);

      run_block(1'b1, 1, 1, -1, 0, -1, 0, 1'b0);
      run_block(1'b0, 2, 2, -1, 0, -1, 0, 1'b1);
      tick();
      chk("no_extra_block", 32'(ready), 32'd1);
      run_block(1'b0, 3, 3, 20, 3, 63, 2, 1'b0);

      // Abort mid-block with reset
      start = 1'b1; new_msg = 1'b1;
      tick();
      start = 1'b0; new_msg = 1'b0;
      for (int i = 0; i < 41; i++) tick();
      chk("abort_cnt_pre", 32'(cnt), 32'd40);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_ready", 32'(ready), 32'd1);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_cnt", 32'(cnt), 32'd0);
      chk("abort_blk_cnt", 32'(blk_cnt), 32'd0);
      chk("abort_blk_cnt_w2", 32'(blk_cnt2), 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 70; i++) begin
         tick();
         if (acc_hash || done || busy) seen = 1'b1;
      end
      chk("abort_no_strobes", 32'(seen), 32'd0);
      $display("abort at cnt=40 ready=%0d blk_cnt=%0d", ready, blk_cnt);

      run_block(1'b1, 1, 1, -1, 0, -1, 0, 1'b0);
      for (int k = 2; k <= 5; k++) run_block(1'b0, k, k % 4, -1, 0, -1, 0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
